// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles every handshake and bus signal around the memory arbiter:
//   fetch port      : if_req, if_addr[13:0]            -> if_ack, if_rdata[7:0]
//   load/store port : ls_req, ls_we, ls_addr[13:0],
//                     ls_wdata[15:0]                   -> ls_ack, ls_rdata[7:0]
//   memory side     : mi_load, mi_store, mi_addr[13:0],
//                     mi_result[15:0]                  <- mi_done, mi_rdata[7:0]
//   error           : err_timeout (sticky)             <- err_clr
//
// Handshake: a requester raises *_req together with its address/data and
// keeps req high until it sees its one-cycle *_ack; it must drop req in the
// cycle after ack, otherwise the still-high req is a new request. The
// arbiter samples address/data only in the cycle it grants. Towards memory,
// mi_load/mi_store stay high with mi_addr/mi_result stable until mi_done is
// seen or the timeout expires; mi_done outside a command is ignored.
//
// Modports: master = the arbiter itself, slave = requesters plus memory.
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_ack;
  logic [7:0]  if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [13:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic [7:0]  ls_rdata;

  logic        mi_load;
  logic        mi_store;
  logic [13:0] mi_addr;
  logic [15:0] mi_result;
  logic        mi_done;
  logic [7:0]  mi_rdata;

  logic        err_timeout;
  logic        err_clr;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
    input  mi_done, mi_rdata, err_clr,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mi_load, mi_store, mi_addr, mi_result, err_timeout
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
    output mi_done, mi_rdata, err_clr,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mi_load, mi_store, mi_addr, mi_result, err_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the memory interface unit between the instruction-fetch port
// (read-only) and the load/store port. Each granted request becomes one
// load or store command that is held until mi_done or until the command
// has been outstanding for TIMEOUT_CYCLES cycles; the winner then gets a
// one-cycle ack with its read data. All outputs are registered.
//
// Parameters:
//   TIMEOUT_CYCLES  1..255, cycles a command may wait before it is aborted
//   FAIR            1 = round-robin on contention, 0 = load/store always wins
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   bus_if       mem_arbiter_if.master (requesters, memory side, error flag)
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 ACK)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          FAIR           = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.master bus_if,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Counter value of the last WAIT cycle a command is allowed to occupy.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_ls_q, last_ls_d;   // 1: load/store won the last grant
  logic        win_ls_q, win_ls_d;     // 1: current transaction is load/store
  logic        mi_load_q, mi_load_d;
  logic        mi_store_q, mi_store_d;
  logic [13:0] mi_addr_q, mi_addr_d;
  logic [15:0] mi_result_q, mi_result_d;
  logic        if_ack_q, if_ack_d;
  logic        ls_ack_q, ls_ack_d;
  logic [7:0]  if_rdata_q, if_rdata_d;
  logic [7:0]  ls_rdata_q, ls_rdata_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        grant_ls;

  // Winner selection; only meaningful when at least one port requests.
  always_comb begin
    grant_ls = bus_if.ls_req;
    if (bus_if.ls_req && bus_if.if_req) begin
      grant_ls = FAIR ? !last_ls_q : 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ls_d   = last_ls_q;
    win_ls_d    = win_ls_q;
    mi_load_d   = mi_load_q;
    mi_store_d  = mi_store_q;
    mi_addr_d   = mi_addr_q;
    mi_result_d = mi_result_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    err_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.if_req || bus_if.ls_req) begin
          win_ls_d  = grant_ls;
          last_ls_d = grant_ls;
          cnt_d     = 8'd0;
          if (grant_ls) begin
            mi_addr_d   = bus_if.ls_addr;
            mi_result_d = bus_if.ls_wdata;
            mi_load_d   = !bus_if.ls_we;
            mi_store_d  = bus_if.ls_we;
          end else begin
            mi_addr_d   = bus_if.if_addr;
            mi_result_d = 16'h0000;
            mi_load_d   = 1'b1;
            mi_store_d  = 1'b0;
          end
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // mi_done wins over the threshold: a late completion is still normal.
        if (bus_if.mi_done) begin
          mi_load_d  = 1'b0;
          mi_store_d = 1'b0;
          if (mi_load_q) begin
            if (win_ls_q) ls_rdata_d = bus_if.mi_rdata;
            else          if_rdata_d = bus_if.mi_rdata;
          end
          if (win_ls_q) ls_ack_d = 1'b1;
          else          if_ack_d = 1'b1;
          state_d = S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          mi_load_d  = 1'b0;
          mi_store_d = 1'b0;
          if (mi_load_q) begin
            if (win_ls_q) ls_rdata_d = 8'h00;
            else          if_rdata_d = 8'h00;
          end
          if (win_ls_q) ls_ack_d = 1'b1;
          else          if_ack_d = 1'b1;
          err_set = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // The ack register is high during this state; it drops by default.
      S_ACK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Setting the flag takes priority over clearing it.
    if (err_set)             err_d = 1'b1;
    else if (bus_if.err_clr) err_d = 1'b0;
    else                     err_d = err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      last_ls_q   <= 1'b1;   // fetch wins the first tie after reset
      win_ls_q    <= 1'b0;
      mi_load_q   <= 1'b0;
      mi_store_q  <= 1'b0;
      mi_addr_q   <= 14'h0000;
      mi_result_q <= 16'h0000;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= 8'h00;
      ls_rdata_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ls_q   <= last_ls_d;
      win_ls_q    <= win_ls_d;
      mi_load_q   <= mi_load_d;
      mi_store_q  <= mi_store_d;
      mi_addr_q   <= mi_addr_d;
      mi_result_q <= mi_result_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus_if.mi_load     = mi_load_q;
  assign bus_if.mi_store    = mi_store_q;
  assign bus_if.mi_addr     = mi_addr_q;
  assign bus_if.mi_result   = mi_result_q;
  assign bus_if.if_ack      = if_ack_q;
  assign bus_if.if_rdata    = if_rdata_q;
  assign bus_if.ls_ack      = ls_ack_q;
  assign bus_if.ls_rdata    = ls_rdata_q;
  assign bus_if.err_timeout = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Main instance: FAIR=1, TIMEOUT_CYCLES=4, directed scenarios then random
// traffic, all checked every cycle against a transaction-level model.
// Second instance: FAIR=0 with both ports requesting forever.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int T = 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rst2_n  = 1'b0;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;
  bit fp_done  = 1'b0;

  mem_arbiter_if ifc();
  mem_arbiter_if ifc2();

  mem_arbiter #(.TIMEOUT_CYCLES(T), .FAIR(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(ifc), .dbg_state_o(dbg_state)
  );

  mem_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .reset_n(rst2_n), .bus_if(ifc2), .dbg_state_o(dbg_state2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk14(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a grant at edge s makes the command visible from s
  // on; it ends at the first later edge that sees mi_done, or at edge s+T.
  // The ack is visible for the cycle after the ending edge and the next
  // grant can be taken no earlier than two edges after it.
  logic        e_load, e_store, e_if_ack, e_ls_ack, e_err;
  logic [13:0] e_addr;
  logic [15:0] e_result;
  logic [7:0]  e_if_rdata, e_ls_rdata;
  bit          m_busy, m_ls, m_read, m_last_ls, m_tmo;
  int unsigned m_start, m_free, edge_n;
  logic [7:0]  m_rd;

  task automatic model_reset();
    e_load = 1'b0; e_store = 1'b0; e_if_ack = 1'b0; e_ls_ack = 1'b0;
    e_err = 1'b0; e_addr = '0; e_result = '0; e_if_rdata = '0; e_ls_rdata = '0;
    m_busy = 1'b0; m_ls = 1'b0; m_read = 1'b0; m_last_ls = 1'b1;
    m_start = 0; m_free = 0; edge_n = 0;
  endtask

  task automatic model_step();
    edge_n++;
    e_if_ack = 1'b0;
    e_ls_ack = 1'b0;
    m_tmo    = 1'b0;
    if (m_busy) begin
      if (ifc.mi_done || (edge_n - m_start) == T) begin
        m_tmo   = !ifc.mi_done;
        m_busy  = 1'b0;
        e_load  = 1'b0;
        e_store = 1'b0;
        if (m_read) begin
          m_rd = m_tmo ? 8'h00 : ifc.mi_rdata;
          if (m_ls) e_ls_rdata = m_rd;
          else      e_if_rdata = m_rd;
        end
        if (m_ls) e_ls_ack = 1'b1;
        else      e_if_ack = 1'b1;
        m_free = edge_n + 2;
      end
    end else if (edge_n >= m_free && (ifc.if_req || ifc.ls_req)) begin
      if (ifc.if_req && ifc.ls_req) m_ls = !m_last_ls;
      else                          m_ls = ifc.ls_req;
      m_last_ls = m_ls;
      if (m_ls) begin
        m_read   = !ifc.ls_we;
        e_addr   = ifc.ls_addr;
        e_result = ifc.ls_wdata;
      end else begin
        m_read   = 1'b1;
        e_addr   = ifc.if_addr;
        e_result = 16'h0000;
      end
      e_load  = m_read;
      e_store = !m_read;
      m_start = edge_n;
      m_busy  = 1'b1;
    end
    if (m_tmo)            e_err = 1'b1;
    else if (ifc.err_clr) e_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk1("mi_load", ifc.mi_load, e_load);
        chk1("mi_store", ifc.mi_store, e_store);
        chk1("if_ack", ifc.if_ack, e_if_ack);
        chk1("ls_ack", ifc.ls_ack, e_ls_ack);
        chk8("if_rdata", ifc.if_rdata, e_if_rdata);
        chk8("ls_rdata", ifc.ls_rdata, e_ls_rdata);
        chk1("err_timeout", ifc.err_timeout, e_err);
        if (e_load || e_store) begin
          chk14("mi_addr", ifc.mi_addr, e_addr);
          chk16("mi_result", ifc.mi_result, e_result);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.ls_req = 1'b0; ifc.ls_we = 1'b0; ifc.ls_addr = '0; ifc.ls_wdata = '0;
    ifc.mi_done = 1'b0; ifc.mi_rdata = '0; ifc.err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_mi_load"}, ifc.mi_load, 1'b0);
    chk1({tag, "_mi_store"}, ifc.mi_store, 1'b0);
    chk14({tag, "_mi_addr"}, ifc.mi_addr, 14'h0000);
    chk16({tag, "_mi_result"}, ifc.mi_result, 16'h0000);
    chk1({tag, "_if_ack"}, ifc.if_ack, 1'b0);
    chk1({tag, "_ls_ack"}, ifc.ls_ack, 1'b0);
    chk8({tag, "_if_rdata"}, ifc.if_rdata, 8'h00);
    chk8({tag, "_ls_rdata"}, ifc.ls_rdata, 8'h00);
    chk1({tag, "_err"}, ifc.err_timeout, 1'b0);
  endtask

  task automatic random_step();
    if (ifc.if_req) begin
      if (ifc.if_ack) ifc.if_req = 1'b0;
      else if ($urandom_range(0, 3) == 0) ifc.if_addr = 14'($urandom);
    end else if ($urandom_range(0, 2) == 0) begin
      ifc.if_req  = 1'b1;
      ifc.if_addr = 14'($urandom);
    end
    if (ifc.ls_req) begin
      if (ifc.ls_ack) ifc.ls_req = 1'b0;
      else if ($urandom_range(0, 3) == 0) begin
        ifc.ls_addr  = 14'($urandom);
        ifc.ls_wdata = 16'($urandom);
        ifc.ls_we    = 1'($urandom_range(0, 1));
      end
    end else if ($urandom_range(0, 2) == 0) begin
      ifc.ls_req   = 1'b1;
      ifc.ls_we    = 1'($urandom_range(0, 1));
      ifc.ls_addr  = 14'($urandom);
      ifc.ls_wdata = 16'($urandom);
    end
    ifc.mi_done  = ($urandom_range(0, 3) == 0);
    ifc.mi_rdata = 8'($urandom);
    ifc.err_clr  = ($urandom_range(0, 15) == 0);
  endtask

  // ---------------- main sequence ----------------
  logic exp_q[$];
  logic exp_g;

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) cyc();
    check_all_zero("reset");
    chk2("reset_state", dbg_state, 2'd0);
    reset_n = 1'b1;
    cyc();
    check_all_zero("post_reset");

    // Single fetch, completion in the first WAIT cycle.
    ifc.if_req = 1'b1; ifc.if_addr = 14'h0123;
    cyc();
    chk1("fetch_mi_load", ifc.mi_load, 1'b1);
    chk14("fetch_mi_addr", ifc.mi_addr, 14'h0123);
    chk16("fetch_mi_result", ifc.mi_result, 16'h0000);
    ifc.mi_done = 1'b1; ifc.mi_rdata = 8'hA5;
    cyc();
    chk1("fetch_ack", ifc.if_ack, 1'b1);
    chk8("fetch_rdata", ifc.if_rdata, 8'hA5);
    chk1("fetch_no_ls_ack", ifc.ls_ack, 1'b0);
    chk1("fetch_load_drop", ifc.mi_load, 1'b0);
    ifc.if_req = 1'b0; ifc.mi_done = 1'b0;
    cyc();
    chk1("fetch_ack_one_cycle", ifc.if_ack, 1'b0);

    // Store held three cycles; port changes after the grant are ignored.
    ifc.ls_req = 1'b1; ifc.ls_we = 1'b1; ifc.ls_addr = 14'h3FFF; ifc.ls_wdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("store_mi_store", ifc.mi_store, 1'b1);
      chk14("store_mi_addr", ifc.mi_addr, 14'h3FFF);
      chk16("store_mi_result", ifc.mi_result, 16'hBEEF);
      if (i == 0) begin ifc.ls_addr = 14'h0001; ifc.ls_wdata = 16'h1234; end
      if (i == 2) ifc.mi_done = 1'b1;
    end
    cyc();
    chk1("store_ack", ifc.ls_ack, 1'b1);
    chk8("store_ls_rdata_kept", ifc.ls_rdata, 8'h00);
    chk1("store_cmd_drop", ifc.mi_store, 1'b0);
    ifc.ls_req = 1'b0; ifc.ls_we = 1'b0; ifc.mi_done = 1'b0;
    cyc();

    // Load completing exactly on the threshold cycle: normal data, no error.
    ifc.ls_req = 1'b1; ifc.ls_addr = 14'h0055;
    for (int i = 0; i < T; i++) begin
      cyc();
      chk1("thr_mi_load", ifc.mi_load, 1'b1);
      if (i == T - 1) begin ifc.mi_done = 1'b1; ifc.mi_rdata = 8'h3C; end
    end
    cyc();
    chk1("thr_ack", ifc.ls_ack, 1'b1);
    chk8("thr_rdata", ifc.ls_rdata, 8'h3C);
    chk1("thr_no_err", ifc.err_timeout, 1'b0);
    ifc.ls_req = 1'b0; ifc.mi_done = 1'b0;
    cyc();

    // Load that never completes: held T cycles, then zero data and error.
    ifc.ls_req = 1'b1; ifc.ls_addr = 14'h0AAA;
    for (int i = 0; i < T; i++) begin
      cyc();
      chk1("tmo_mi_load", ifc.mi_load, 1'b1);
    end
    cyc();
    chk1("tmo_load_drop", ifc.mi_load, 1'b0);
    chk1("tmo_ack", ifc.ls_ack, 1'b1);
    chk8("tmo_rdata", ifc.ls_rdata, 8'h00);
    chk1("tmo_err", ifc.err_timeout, 1'b1);
    ifc.ls_req = 1'b0; ifc.err_clr = 1'b1;
    cyc();
    chk1("tmo_err_cleared", ifc.err_timeout, 1'b0);
    ifc.err_clr = 1'b0;

    // mi_done while idle is ignored.
    ifc.mi_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("idle_done_no_if_ack", ifc.if_ack, 1'b0);
      chk1("idle_done_no_ls_ack", ifc.ls_ack, 1'b0);
    end
    ifc.mi_done = 1'b0;
    cyc();

    // Reset in the middle of a store: outputs drop at once, then re-grant.
    ifc.ls_req = 1'b1; ifc.ls_we = 1'b1; ifc.ls_addr = 14'h1234; ifc.ls_wdata = 16'h5A5A;
    cyc();
    chk1("rst_pre_store", ifc.mi_store, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    cyc();
    reset_n = 1'b1;
    cyc();
    chk1("rst_regrant_store", ifc.mi_store, 1'b1);
    chk14("rst_regrant_addr", ifc.mi_addr, 14'h1234);
    ifc.mi_done = 1'b1;
    cyc();
    chk1("rst_regrant_ack", ifc.ls_ack, 1'b1);
    ifc.ls_req = 1'b0; ifc.ls_we = 1'b0; ifc.mi_done = 1'b0;
    cyc();

    // Round-robin contention from reset: fetch, ls, fetch, ls.
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    ifc.if_req = 1'b1; ifc.ls_req = 1'b1; ifc.ls_we = 1'b0;
    ifc.mi_done = 1'b1; ifc.mi_rdata = 8'h77;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      cyc();
      if (ifc.if_ack || ifc.ls_ack) begin
        exp_g = exp_q.pop_front();
        chk1("fair_grant_ls", ifc.ls_ack, exp_g);
        chk1("fair_single_ack", ifc.if_ack ^ ifc.ls_ack, 1'b1);
        if (exp_q.size() == 0) begin
          ifc.if_req = 1'b0; ifc.ls_req = 1'b0; ifc.mi_done = 1'b0;
        end
      end
    end
    chk32("fair_grants_left", exp_q.size(), 0);
    clear_inputs();
    repeat (2) cyc();

    // Random traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      random_step();
    end
    cyc();
    clear_inputs();
    ifc.mi_done = 1'b1;
    repeat (8) cyc();
    ifc.mi_done = 1'b0;
    repeat (2) cyc();

    for (int i = 0; i < 200 && !fp_done; i++) cyc();
    chk1("fp_finished", fp_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- fixed-priority instance ----------------
  int fp_got;

  initial begin
    ifc2.if_req = 1'b0; ifc2.if_addr = 14'h0100;
    ifc2.ls_req = 1'b0; ifc2.ls_we = 1'b0; ifc2.ls_addr = 14'h0200; ifc2.ls_wdata = '0;
    ifc2.mi_done = 1'b0; ifc2.mi_rdata = 8'h00; ifc2.err_clr = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    chk2("fp_reset_state", dbg_state2, 2'd0);
    chk1("fp_reset_ls_ack", ifc2.ls_ack, 1'b0);
    rst2_n = 1'b1;
    ifc2.if_req = 1'b1; ifc2.ls_req = 1'b1;
    ifc2.mi_done = 1'b1; ifc2.mi_rdata = 8'h11;
    fp_got = 0;
    for (int i = 0; i < 60 && fp_got < 4; i++) begin
      @(negedge clk);
      if (ifc2.if_ack || ifc2.ls_ack) begin
        chk1("fp_grant_ls", ifc2.ls_ack, 1'b1);
        chk1("fp_no_fetch_ack", ifc2.if_ack, 1'b0);
        chk8("fp_ls_rdata", ifc2.ls_rdata, 8'h11);
        fp_got++;
      end
    end
    chk32("fp_grant_count", fp_got, 4);
    ifc2.if_req = 1'b0; ifc2.ls_req = 1'b0; ifc2.mi_done = 1'b0;
    fp_done = 1'b1;
  end

endmodule
